// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and helpers for the instruction-fetch front end.
//   XLEN         architectural register / address width
//   INSTR_BYTES  bytes per instruction (PC increment)
//   fq_entry_t   one fetch-queue entry: {pc, instr}
//   ptr_w()      pointer width for a queue of the given depth
package fetch_pkg;
  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fq_entry_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous in-order FIFO of fq_entry_t with flush.
//   i_clk, i_rst_n   clock, async active-low reset
//   i_flush          discard all entries (wins over push/pop)
//   i_push, i_data   enqueue one entry
//   i_pop            dequeue head (ignored when empty)
//   o_head           head entry (meaningful only when !o_empty)
//   o_full, o_empty  status
//   o_count          occupancy
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  fq_entry_t                    i_data,
  input  logic                         i_pop,
  output fq_entry_t                    o_head,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fq_entry_t      r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           w_do_push;
  logic           w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !i_flush;
  assign w_do_pop  = i_pop && !i_flush && !o_empty;

  // Storage needs no reset: entries are only observed when counted valid.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CW'(1);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end. Owns the PC, issues sequential
// imem requests under a credit limit, queues returned instructions for
// decode, and drops stale responses after a redirect.
//   clk, rst_n                     clock, async active-low reset
//   redirect_valid, redirect_pc    resolved taken branch/jump target
//   imem_req_valid/ready/addr      fetch request channel
//   imem_rsp_valid/data            in-order responses, always accepted
//   if_valid/ready/pc/instr        instruction stream to decode
// Optional macro FETCH_BYPASS_EN: present a response combinationally when
// the queue is empty and decode is ready (0-cycle latency).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FQ_DEPTH        = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);
  localparam int IW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(FQ_DEPTH + 1);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [IW-1:0] r_inflight;
  logic [IW-1:0] r_drop;
  logic          r_active;

  logic [CW-1:0] w_count;
  logic          w_empty;
  logic          w_full;
  fq_entry_t     w_head;
  fq_entry_t     w_push_data;
  logic [31:0]   w_committed;
  logic [31:0]   w_target;
  logic          w_req_fire;
  logic          w_rsp_drop;
  logic          w_bypass;
  logic          w_push;
  logic          w_pop;

  assign w_target = {redirect_pc[31:2], 2'b00};

  // Slots the queue must reserve: pending useful responses plus entries held.
  assign w_committed = 32'(r_inflight) - 32'(r_drop) + 32'(w_count);

  // r_active holds requests off until the first edge after reset release.
  assign imem_req_valid = r_active
                        && (32'(r_inflight) < 32'(MAX_OUTSTANDING))
                        && (w_committed < 32'(FQ_DEPTH))
                        && !redirect_valid;
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  // A response in the redirect cycle is stale as well.
  assign w_rsp_drop = imem_rsp_valid && ((r_drop != '0) || redirect_valid);

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_empty && if_ready && (r_drop == '0) && !redirect_valid
                  && imem_rsp_valid;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push      = imem_rsp_valid && !w_rsp_drop && !w_bypass && !w_full;
  assign w_push_data = '{pc: r_rsp_pc, instr: imem_rsp_data};
  assign w_pop       = !w_empty && if_ready && !redirect_valid;

  assign if_valid = (!w_empty && !redirect_valid) || w_bypass;
  assign if_pc    = w_bypass ? r_rsp_pc
                  : (if_valid ? w_head.pc : 32'h0);
  assign if_instr = w_bypass ? imem_rsp_data
                  : (if_valid ? w_head.instr : 32'h0);

  fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_inflight <= '0;
      r_drop     <= '0;
      r_active   <= 1'b0;
    end else begin
      r_active   <= 1'b1;
      r_inflight <= r_inflight + IW'(w_req_fire) - IW'(imem_rsp_valid);
      if (redirect_valid) begin
        r_fetch_pc <= w_target;
        r_rsp_pc   <= w_target;
        // Everything still outstanding after this cycle is stale.
        r_drop     <= r_inflight - IW'(imem_rsp_valid);
      end else begin
        if (w_req_fire)                        r_fetch_pc <= r_fetch_pc + 32'(INSTR_BYTES);
        if (imem_rsp_valid && (r_drop != '0))  r_drop     <= r_drop - IW'(1);
        if (w_push || w_bypass)                r_rsp_pc   <= r_rsp_pc + 32'(INSTR_BYTES);
      end
    end
  end
endmodule
